serial_addsub_unit: RTL and testbench

Parametrised LSB-first bit-serial adder/subtractor with a start/done handshake, replacing the fixed 4-bit serial adder in the arithmetic lab datapath. It accepts two WIDTH-bit parallel operands, processes one bit per clock through a single full-adder cell, and returns a parallel sum with carry, signed-overflow and a one-cycle completion pulse. It sits between the operand register file and the result bus, where area matters more than latency.

---
 rtl/serial_addsub_unit_pkg.sv | 20 ++
 rtl/serial_addsub_unit_if.sv | 38 +++
 rtl/serial_addsub_unit_full_adder_bit.sv | 20 ++
 rtl/serial_addsub_unit.sv | 133 +++++++++++++
 tb/tb_serial_addsub_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_addsub_pkg
// Description : Shared types and width-independent constants for the
//               bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

  // Controller states: waiting for a request, or shifting bits through the cell
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The unit comes out of reset able to accept a request immediately
  localparam logic READY_RST = 1'b1;

endpackage : serial_addsub_pkg
`default_nettype wire

// File: rtl/serial_addsub_unit_if.sv
`default_nettype none
// ============================================================================
// Interface   : serial_addsub_unit_if
// Description : Request/operand and result/status bundle of the bit-serial
//               adder/subtractor. The master issues requests, the slave is the
//               arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_unit_if #(
  parameter int WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             ready;
  logic             busy;
  logic [IDX_W-1:0] bit_idx;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             done;

  modport master (
    output start, a, b, sub, cin,
    input  ready, busy, bit_idx, sum, cout, overflow, done
  );

  modport slave (
    input  start, a, b, sub, cin,
    output ready, busy, bit_idx, sum, cout, overflow, done
  );

endinterface : serial_addsub_unit_if
`default_nettype wire

// File: rtl/serial_addsub_unit_full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : Single combinational full-adder cell; the only arithmetic
//               element of the serial unit.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_bit
`default_nettype wire

// File: rtl/serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_unit
// Description : LSB-first bit-serial adder/subtractor. Operands are captured
//               on the accepting edge, one bit per clock passes through a
//               single full-adder cell, and the parallel result, carry and
//               signed overflow are published together with a one-cycle
//               done pulse after WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_unit
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_addsub_unit_if.slave  bus
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             fa_s;
  logic             fa_co;

  // The single arithmetic cell works on the current LSBs and the running carry
  full_adder_bit u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state logic: accept in IDLE, shift one bit per cycle in RUN and
  // publish the result only on the final bit so no partial value is visible
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1; cin only matters when adding
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // carry_q here is the carry into the MSB, fa_co the carry out
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset that also aborts a run
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= READY_RST;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = ~ready_q;
  assign bus.bit_idx  = idx_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;

endmodule : serial_addsub_unit
`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub_unit
// Description : Self-checking bench for serial_addsub_unit at WIDTH 8, 2 and
//               32 against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_unit_if #(.WIDTH(8))  if8 ();
  serial_addsub_unit_if #(.WIDTH(2))  if2 ();
  serial_addsub_unit_if #(.WIDTH(32)) if32 ();

  serial_addsub_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_addsub_unit #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
  serial_addsub_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  int checks = 0;
  int errors = 0;

  // Observations of the most recent operation
  logic [63:0] o_sum;
  logic        o_cout;
  logic        o_ovf;
  int          o_lat;
  bit          o_hs_ok;
  bit          o_acc_done0;

  // Arithmetic reference: plain integer add/subtract on WIDTH-bit values
  function automatic void ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic sub, input logic cin,
                                    output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask, aa, bb, t;
    longint sa, sb, r, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    aa   = a & mask;
    bb   = b & mask;
    sa   = aa[w-1] ? longint'(aa) - (longint'(1) << w) : longint'(aa);
    sb   = bb[w-1] ? longint'(bb) - (longint'(1) << w) : longint'(bb);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    if (!sub) begin
      t  = aa + bb + 64'(cin);
      s  = t & mask;
      co = t[w];
      r  = sa + sb + longint'(cin);
    end else begin
      s  = (aa - bb) & mask;
      co = (aa >= bb);
      r  = sa - sb;
    end
    ov = (r > smax) || (r < smin);
  endfunction

  task automatic drive(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic cin, input logic st);
    case (w)
      2:  begin if2.a  = a[1:0];  if2.b  = b[1:0];  if2.sub  = sub; if2.cin  = cin; if2.start  = st; end
      32: begin if32.a = a[31:0]; if32.b = b[31:0]; if32.sub = sub; if32.cin = cin; if32.start = st; end
      default: begin if8.a = a[7:0]; if8.b = b[7:0]; if8.sub = sub; if8.cin = cin; if8.start = st; end
    endcase
  endtask

  task automatic sample(input int w, output logic [63:0] sm, output logic co, output logic ov,
                        output logic dn, output logic rdy, output int idx);
    case (w)
      2: begin
        sm = 64'(if2.sum); co = if2.cout; ov = if2.overflow; dn = if2.done; rdy = if2.ready;
        idx = int'(if2.bit_idx);
      end
      32: begin
        sm = 64'(if32.sum); co = if32.cout; ov = if32.overflow; dn = if32.done; rdy = if32.ready;
        idx = int'(if32.bit_idx);
      end
      default: begin
        sm = 64'(if8.sum); co = if8.cout; ov = if8.overflow; dn = if8.done; rdy = if8.ready;
        idx = int'(if8.bit_idx);
      end
    endcase
  endtask

  // Present a request for one edge, then scramble the operand inputs
  task automatic start_op(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cin);
    logic [63:0] sm; logic co, ov, dn, rdy; int idx;
    drive(w, a, b, sub, cin, 1'b1);
    @(posedge clk); #1;
    drive(w, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);
    sample(w, sm, co, ov, dn, rdy, idx);
    o_acc_done0 = !dn;
  endtask

  // Count edges until done (bounded); optionally keep poking start meanwhile
  task automatic wait_done(input int w, input bit poke);
    logic [63:0] sm; logic co, ov, dn, rdy; int idx;
    o_lat   = 0;
    o_hs_ok = 1'b1;
    o_sum   = '0; o_cout = 1'b0; o_ovf = 1'b0;
    while (o_lat < w + 4) begin
      if (poke)
        drive(w, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b1);
      @(posedge clk); #1;
      o_lat++;
      sample(w, sm, co, ov, dn, rdy, idx);
      if (dn) begin
        if (!rdy) o_hs_ok = 1'b0;
        o_sum = sm; o_cout = co; o_ovf = ov;
        break;
      end else if (rdy || idx != o_lat) begin
        o_hs_ok = 1'b0;
      end
    end
    if (poke) drive(w, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++; if (if8.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if8.ready); end
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if8.busy); end
    checks++; if (if8.bit_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", if8.bit_idx); end
    checks++; if ({if8.sum, if8.cout, if8.overflow, if8.done} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b done=%b want all 0",
                         if8.sum, if8.cout, if8.overflow, if8.done); end
    checks++; if (if2.ready !== 1'b1 || if32.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_w got %b/%b want 1/1", if2.ready, if32.ready); end
  endtask

  task automatic test_directed();
    logic [7:0] va [7] = '{8'h5A, 8'hFF, 8'h00, 8'h10, 8'h80, 8'h7F, 8'h33};
    logic [7:0] vb [7] = '{8'h33, 8'h01, 8'h00, 8'h20, 8'h01, 8'h00, 8'h33};
    logic       vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       vc [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] es [7] = '{8'h8D, 8'h00, 8'h01, 8'hF0, 8'h7F, 8'h80, 8'h00};
    logic       ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      start_op(8, 64'(va[i]), 64'(vb[i]), vs[i], vc[i]);
      wait_done(8, 1'b0);
      checks++; if (o_sum[7:0] !== es[i] || o_cout !== ec[i] || o_ovf !== eo[i]) begin
        errors++; $display("FAIL directed_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           i, o_sum[7:0], o_cout, o_ovf, es[i], ec[i], eo[i]); end
      checks++; if (o_lat != 8 || !o_hs_ok) begin
        errors++; $display("FAIL directed_lat_%0d got lat=%0d hs=%b want lat=8 hs=1", i, o_lat, o_hs_ok); end
      @(posedge clk); #1;
      checks++; if (if8.done !== 1'b0 || if8.sum !== es[i]) begin
        errors++; $display("FAIL directed_hold_%0d got done=%b sum=%h want done=0 sum=%h",
                           i, if8.done, if8.sum, es[i]); end
    end
  endtask

  task automatic test_start_during_run();
    start_op(8, 64'h5A, 64'h33, 1'b0, 1'b0);
    wait_done(8, 1'b1);
    checks++; if (o_sum[7:0] !== 8'h8D || o_cout !== 1'b0 || o_ovf !== 1'b1 || o_lat != 8) begin
      errors++; $display("FAIL start_in_run got sum=%h cout=%b ovf=%b lat=%0d want 8d/0/1/8",
                         o_sum[7:0], o_cout, o_ovf, o_lat); end
    @(posedge clk); #1;
    checks++; if (if8.ready !== 1'b1 || if8.done !== 1'b0) begin
      errors++; $display("FAIL start_in_run_queued got ready=%b done=%b want 1/0", if8.ready, if8.done); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] es; logic ec, eo;
    logic [7:0] va [3] = '{8'h12, 8'hC8, 8'h01};
    logic [7:0] vb [3] = '{8'h34, 8'h64, 8'h02};
    logic       vs [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start_op(8, 64'(va[i]), 64'(vb[i]), vs[i], 1'b0);
      if (i > 0) begin
        checks++; if (!o_acc_done0) begin errors++; $display("FAIL b2b_done_twice op=%0d got 1 want 0", i); end
      end
      wait_done(8, 1'b0);
      ref_model(8, 64'(va[i]), 64'(vb[i]), vs[i], 1'b0, es, ec, eo);
      checks++; if (o_sum !== es || o_cout !== ec || o_ovf !== eo || o_lat != 8 || !o_hs_ok) begin
        errors++; $display("FAIL b2b_%0d got sum=%h cout=%b ovf=%b lat=%0d want sum=%h cout=%b ovf=%b lat=8",
                           i, o_sum, o_cout, o_ovf, o_lat, es, ec, eo); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    start_op(8, 64'h5A, 64'h33, 1'b0, 1'b0);
    wait_done(8, 1'b0);
    start_op(8, 64'hFF, 64'h0F, 1'b0, 1'b1);
    for (int k = 0; k < 10 && if8.bit_idx != 3'd3; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (if8.ready !== 1'b1 || if8.busy !== 1'b0 || if8.bit_idx !== 3'd0) begin
      errors++; $display("FAIL midrst_state got ready=%b busy=%b idx=%0d want 1/0/0",
                         if8.ready, if8.busy, if8.bit_idx); end
    checks++; if (if8.sum !== 8'h00 || if8.cout !== 1'b0 || if8.overflow !== 1'b0 || if8.done !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got sum=%h cout=%b ovf=%b done=%b want 0",
                         if8.sum, if8.cout, if8.overflow, if8.done); end
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if8.done) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midrst_done got 1 want 0"); end
    // Reset wins over a simultaneous request
    drive(8, 64'h11, 64'h22, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(8, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (if8.ready !== 1'b1) begin errors++; $display("FAIL rst_over_start got ready=%b want 1", if8.ready); end
    start_op(8, 64'h80, 64'h01, 1'b1, 1'b0);
    wait_done(8, 1'b0);
    checks++; if (o_sum[7:0] !== 8'h7F || o_cout !== 1'b1 || o_ovf !== 1'b1 || o_lat != 8) begin
      errors++; $display("FAIL midrst_fresh got sum=%h cout=%b ovf=%b lat=%0d want 7f/1/1/8",
                         o_sum[7:0], o_cout, o_ovf, o_lat); end
  endtask

  task automatic test_random(input int w, input int n);
    logic [63:0] a, b, es; logic sub, cin, ec, eo;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      sub = 1'($urandom); cin = 1'($urandom);
      ref_model(w, a, b, sub, cin, es, ec, eo);
      start_op(w, a, b, sub, cin);
      wait_done(w, 1'($urandom));
      checks++; if (o_sum !== es || o_cout !== ec || o_ovf !== eo) begin
        errors++; $display("FAIL random_w%0d_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           w, i, o_sum, o_cout, o_ovf, es, ec, eo); end
      checks++; if (o_lat != w || !o_hs_ok) begin
        errors++; $display("FAIL random_lat_w%0d_%0d got lat=%0d hs=%b want lat=%0d hs=1",
                           w, i, o_lat, o_hs_ok, w); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    drive(8, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(2, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(32, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_directed();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random(8, 20);
    test_random(2, 20);
    test_random(32, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_addsub_unit
`default_nettype wire
